sha256_arbiter: RTL and testbench

SHA256_ARBITER -- requirements
Module: sha256_arbiter

---
 rtl/sha256_arbiter.sv | 179 +++++++++++++++++
 tb/tb_sha256_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_arbiter.sv
// rtl/sha256_arbiter.sv - two-requester round-robin front end for a byte-fed SHA-256 processor
module sha256_arbiter #(
  parameter int BLOCK_GAP = 96
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [7:0]   req0_data,
  input  logic         req0_last,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [7:0]   req1_data,
  input  logic         req1_last,
  output logic         req1_ready,
  output logic         resp_valid,
  output logic         resp_id,
  output logic [255:0] resp_hash,
  output logic         p_rst,
  output logic         p_start,
  output logic         p_valid,
  output logic         p_last,
  output logic [7:0]   p_data,
  input  logic [255:0] p_hash,
  input  logic         p_done
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    START,
    STREAM,
    GAP,
    WAIT_DONE,
    RESP
  } state_e;

  // One timer serves both the 2-cycle CLEAR and the BLOCK_GAP stall.
  localparam int TW = (BLOCK_GAP > 2) ? $clog2(BLOCK_GAP) : 1;
  localparam logic [TW-1:0] GAP_LAST = TW'(BLOCK_GAP - 1);

  state_e         state_q, state_d;
  logic           grant_q, grant_d;
  logic           last_grant_q, last_grant_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic           p_rst_q, p_rst_d;
  logic           p_valid_q, p_valid_d;
  logic           p_last_q, p_last_d;
  logic [7:0]     p_data_q, p_data_d;
  logic           resp_valid_q, resp_valid_d;
  logic           resp_id_q, resp_id_d;
  logic [255:0]   resp_hash_q, resp_hash_d;

  logic           sel_valid;
  logic           sel_last;
  logic [7:0]     sel_data;
  logic           accept;

  assign sel_valid = grant_q ? req1_valid : req0_valid;
  assign sel_last  = grant_q ? req1_last  : req0_last;
  assign sel_data  = grant_q ? req1_data  : req0_data;
  assign accept    = (state_q == STREAM) && sel_valid;

  // Ready comes only from registered state so requesters never see a loop through valid.
  assign req0_ready = (state_q == STREAM) && !grant_q;
  assign req1_ready = (state_q == STREAM) &&  grant_q;
  assign p_start    = (state_q == START);
  assign p_rst      = p_rst_q;
  assign p_valid    = p_valid_q;
  assign p_last     = p_last_q;
  assign p_data     = p_data_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_hash  = resp_hash_q;

  // Next-state, grant, byte forwarding and digest capture.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    tmr_d        = tmr_q;
    resp_id_d    = resp_id_q;
    resp_hash_d  = resp_hash_q;
    p_valid_d    = accept;
    p_last_d     = accept && sel_last;
    p_data_d     = accept ? sel_data : 8'h00;

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          // On a tie the requester that did not win last time goes next.
          grant_d      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
          last_grant_d = grant_d;
          tmr_d        = '0;
          state_d      = CLEAR;
        end
      end
      CLEAR: begin
        if (tmr_q == TW'(1)) begin
          cnt_d   = '0;
          state_d = START;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      START: begin
        tmr_d   = '0;
        state_d = STREAM;
      end
      STREAM: begin
        if (accept) begin
          cnt_d = cnt_q + 6'd1;
          if (sel_last) begin
            state_d = WAIT_DONE;
          end else if (cnt_q == 6'd63) begin
            tmr_d   = '0;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (tmr_q == GAP_LAST) begin
          state_d = STREAM;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (p_done) begin
          resp_hash_d = p_hash;
          resp_id_d   = grant_q;
          state_d     = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    p_rst_d      = (state_d == CLEAR);
    resp_valid_d = (state_d == RESP);
  end

  // State register; reset aborts any job and holds the processor in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      tmr_q        <= '0;
      p_rst_q      <= 1'b1;
      p_valid_q    <= 1'b0;
      p_last_q     <= 1'b0;
      p_data_q     <= 8'h00;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_hash_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      tmr_q        <= tmr_d;
      p_rst_q      <= p_rst_d;
      p_valid_q    <= p_valid_d;
      p_last_q     <= p_last_d;
      p_data_q     <= p_data_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_hash_q  <= resp_hash_d;
    end
  end

endmodule

// File: tb/tb_sha256_arbiter.sv
// tb/tb_sha256_arbiter.sv - randomized bench with behavioural arbiter and processor models
module tb_sha256_arbiter;

  localparam int GAP = 96;
  localparam logic [255:0] INIT = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam int PH_IDLE   = 0;
  localparam int PH_CLEAR  = 1;
  localparam int PH_START  = 2;
  localparam int PH_STREAM = 3;
  localparam int PH_GAP    = 4;
  localparam int PH_WAIT   = 5;
  localparam int PH_RESP   = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_last, req0_ready;
  logic [7:0]   req0_data;
  logic         req1_valid, req1_last, req1_ready;
  logic [7:0]   req1_data;
  logic         resp_valid, resp_id;
  logic [255:0] resp_hash;
  logic         p_rst, p_start, p_valid, p_last;
  logic [7:0]   p_data;
  logic [255:0] p_hash;
  logic         p_done;

  always #5 clk = ~clk;

  sha256_arbiter #(.BLOCK_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_hash(resp_hash),
    .p_rst(p_rst), .p_start(p_start), .p_valid(p_valid), .p_last(p_last), .p_data(p_data),
    .p_hash(p_hash), .p_done(p_done)
  );

  int checks = 0;
  int errors = 0;

  logic [8:0]   q0[$];
  logic [8:0]   q1[$];
  logic [255:0] exp0[$];
  logic [255:0] exp1[$];
  int           resp_ids[$];
  int           stall0[$];
  int           stall1[$];
  int           pv_count = 0;
  int           resp_count = 0;
  int           acc0_total = 0;
  bit           bubbles = 1'b0;
  logic         a0, a1;

  // Arbiter reference: job phase, remaining timer, bytes taken in this job.
  int           m_phase, m_timer, m_nbytes;
  logic         m_grant, m_last_grant, m_prst, m_pv, m_pl, m_rv, m_rid;
  logic [7:0]   m_pd;
  logic [255:0] m_rhash;
  // Processor stand-in.
  logic [255:0] pr_acc;
  int           pr_cnt;
  int           run0, run1;
  bit           armed0, armed1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [255:0] mix(input logic [255:0] h, input logic [7:0] b);
    logic [255:0] r;
    r = {h[246:0], h[255:247]} ^ {32{b}};
    r[63:0] = r[63:0] + ({56'd0, b} * 64'h9e3779b97f4a7c15);
    return r;
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_timer = 0; m_nbytes = 0;
    m_grant = 1'b0; m_last_grant = 1'b1; m_prst = 1'b1;
    m_pv = 1'b0; m_pl = 1'b0; m_pd = 8'h00;
    m_rv = 1'b0; m_rid = 1'b0; m_rhash = '0;
  endtask

  task automatic model_step();
    logic acc, sl;
    logic [7:0] sd;
    m_pv = 1'b0; m_pl = 1'b0; m_pd = 8'h00;
    case (m_phase)
      PH_IDLE: if (req0_valid || req1_valid) begin
        if (req0_valid && req1_valid) m_grant = !m_last_grant;
        else m_grant = req1_valid;
        m_last_grant = m_grant;
        m_phase = PH_CLEAR; m_timer = 2;
      end
      PH_CLEAR: begin
        m_timer--;
        if (m_timer == 0) m_phase = PH_START;
      end
      PH_START: begin m_phase = PH_STREAM; m_nbytes = 0; end
      PH_STREAM: begin
        acc = m_grant ? req1_valid : req0_valid;
        sl  = m_grant ? req1_last  : req0_last;
        sd  = m_grant ? req1_data  : req0_data;
        if (acc) begin
          m_pv = 1'b1; m_pd = sd; m_pl = sl;
          m_nbytes++;
          if (sl) m_phase = PH_WAIT;
          else if (m_nbytes % 64 == 0) begin m_phase = PH_GAP; m_timer = GAP; end
        end
      end
      PH_GAP: begin
        m_timer--;
        if (m_timer == 0) m_phase = PH_STREAM;
      end
      PH_WAIT: if (p_done) begin m_rhash = p_hash; m_rid = m_grant; m_phase = PH_RESP; end
      PH_RESP: m_phase = PH_IDLE;
      default: m_phase = PH_IDLE;
    endcase
    m_prst = (m_phase == PH_CLEAR);
    m_rv   = (m_phase == PH_RESP);
  endtask

  // Requester drivers: present the head of each byte queue, hold it until taken.
  initial begin
    req0_valid = 0; req0_data = 0; req0_last = 0;
    req1_valid = 0; req1_data = 0; req1_last = 0;
    forever begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (a0 && q0.size() > 0) void'(q0.pop_front());
      if (a1 && q1.size() > 0) void'(q1.pop_front());
      if (q0.size() == 0) req0_valid = 1'b0;
      else if (a0 || !req0_valid) req0_valid = !(bubbles && $urandom_range(0, 3) == 0);
      if (q1.size() == 0) req1_valid = 1'b0;
      else if (a1 || !req1_valid) req1_valid = !(bubbles && $urandom_range(0, 3) == 0);
      if (q0.size() > 0) {req0_last, req0_data} = q0[0]; else {req0_last, req0_data} = 9'h000;
      if (q1.size() > 0) {req1_last, req1_data} = q1[0]; else {req1_last, req1_data} = 9'h000;
    end
  end

  // Compare every cycle, then run the processor stand-in and advance the reference.
  initial begin
    p_done = 1'b0; p_hash = '0; pr_acc = INIT; pr_cnt = 0;
    run0 = 0; run1 = 0; armed0 = 0; armed1 = 0;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
        run0 = 0; run1 = 0; armed0 = 0; armed1 = 0;
      end
      chk("req0_ready", 256'(req0_ready), 256'(m_phase == PH_STREAM && !m_grant));
      chk("req1_ready", 256'(req1_ready), 256'(m_phase == PH_STREAM && m_grant));
      chk("p_rst", 256'(p_rst), 256'(m_prst));
      chk("p_start", 256'(p_start), 256'(m_phase == PH_START));
      chk("p_valid", 256'(p_valid), 256'(m_pv));
      if (m_pv) begin
        chk("p_data", 256'(p_data), 256'(m_pd));
        chk("p_last", 256'(p_last), 256'(m_pl));
      end
      chk("resp_valid", 256'(resp_valid), 256'(m_rv));
      chk("resp_id", 256'(resp_id), 256'(m_rid));
      chk("resp_hash", resp_hash, m_rhash);

      if (resp_valid) begin
        resp_count++;
        resp_ids.push_back(int'(resp_id));
        if (!resp_id) begin
          if (exp0.size() == 0) chk("e2e_unexpected0", 256'(1), 256'(0));
          else chk("e2e_hash0", resp_hash, exp0.pop_front());
        end else begin
          if (exp1.size() == 0) chk("e2e_unexpected1", 256'(1), 256'(0));
          else chk("e2e_hash1", resp_hash, exp1.pop_front());
        end
      end
      if (p_valid) pv_count++;
      if (req0_valid && req0_ready) acc0_total++;

      if (req0_ready) begin
        if (run0 > 0) stall0.push_back(run0);
        run0 = 0; armed0 = req0_valid && !req0_last;
      end else if (armed0) run0++;
      if (req1_ready) begin
        if (run1 > 0) stall1.push_back(run1);
        run1 = 0; armed1 = req1_valid && !req1_last;
      end else if (armed1) run1++;

      p_done = 1'b0;
      p_hash = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
      if (p_rst) begin
        pr_acc = INIT; pr_cnt = 0;
      end else begin
        if (p_start) pr_acc = INIT;
        if (p_valid) begin
          pr_acc = mix(pr_acc, p_data);
          if (p_last) pr_cnt = $urandom_range(1, 6);
        end else if (pr_cnt > 0) begin
          pr_cnt--;
          if (pr_cnt == 0) begin p_done = 1'b1; p_hash = pr_acc; end
        end
      end

      if (rst_n) model_step();
    end
  end

  // kind 0: random bytes, 1: all 0x61, 2: 61 62 63 ...
  task automatic send(input int n, input int len, input int kind);
    logic [255:0] h;
    logic [7:0]   b;
    h = INIT;
    for (int i = 0; i < len; i++) begin
      case (kind)
        0: b = 8'($urandom());
        1: b = 8'h61;
        default: b = 8'h61 + 8'(i);
      endcase
      h = mix(h, b);
      if (n == 0) q0.push_back({(i == len - 1), b});
      else q1.push_back({(i == len - 1), b});
    end
    if (n == 0) exp0.push_back(h); else exp1.push_back(h);
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    while ((q0.size() + q1.size() + exp0.size() + exp1.size()) > 0 && k < bound) begin
      @(posedge clk);
      k++;
    end
    if (k >= bound) chk("drain_timeout", 256'(1), 256'(0));
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int saved, base, k, len;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);

    send(0, 3, 0); send(0, 5, 0); send(1, 4, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    drain(3000);
    chk("tie_count", 256'(resp_ids.size()), 256'(3));
    if (resp_ids.size() == 3) begin
      chk("tie_first", 256'(resp_ids[0]), 256'(0));
      chk("tie_second", 256'(resp_ids[1]), 256'(1));
      chk("tie_third", 256'(resp_ids[2]), 256'(0));
    end

    resp_ids.delete(); pv_count = 0;
    send(0, 3, 2);
    drain(2000);
    chk("abc_resp_count", 256'(resp_ids.size()), 256'(1));
    if (resp_ids.size() == 1) chk("abc_id", 256'(resp_ids[0]), 256'(0));
    chk("abc_bytes", 256'(pv_count), 256'(3));

    resp_ids.delete(); pv_count = 0; stall1.delete();
    send(1, 64, 1);
    drain(2000);
    chk("a64_no_gap", 256'(stall1.size()), 256'(0));
    if (resp_ids.size() == 1) chk("a64_id", 256'(resp_ids[0]), 256'(1));
    else chk("a64_resp_count", 256'(resp_ids.size()), 256'(1));
    chk("a64_bytes", 256'(pv_count), 256'(64));

    resp_ids.delete(); pv_count = 0; stall0.delete();
    send(0, 100, 0);
    drain(3000);
    chk("b100_gap_runs", 256'(stall0.size()), 256'(1));
    if (stall0.size() == 1) chk("b100_gap_len", 256'(stall0[0]), 256'(96));
    chk("b100_bytes", 256'(pv_count), 256'(100));

    saved = resp_count;
    base = acc0_total;
    send(0, 30, 0);
    k = 0;
    while (acc0_total < base + 10 && k < 500) begin @(posedge clk); k++; end
    if (k >= 500) chk("reset_wait_timeout", 256'(1), 256'(0));
    #3 rst_n = 1'b0;
    q0.delete(); exp0.delete();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    chk("reset_no_resp", 256'(resp_count), 256'(saved));
    send(0, 3, 2);
    drain(2000);
    chk("post_reset_abc", 256'(resp_count), 256'(saved + 1));

    bubbles = 1'b1;
    base = resp_count;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 7))
        0: len = 1;
        1: len = 2;
        2: len = 63;
        3: len = 64;
        4: len = 65;
        5: len = 128;
        default: len = $urandom_range(1, 150);
      endcase
      send($urandom_range(0, 1), len, 0);
      repeat ($urandom_range(0, 20)) @(posedge clk);
    end
    drain(40000);
    chk("random_resp_count", 256'(resp_count - base), 256'(24));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
